// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the single register-file write port between the main
//            pipeline writeback (A, priority) and the multi-cycle unit (B).
//            A starvation counter forces a grant to B after it has stalled
//            STARVE_LIMIT cycles. The write port is registered and writes to
//            $0 are consumed without asserting the write enable.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int STARVE_LIMIT = 4   // legal range 1..15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          rf_src,
    output logic          forced
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        PRIO_A  = 1'b0,
        FORCE_B = 1'b1
    } state_t;

    state_t        r_state;
    logic [3:0]    r_starve_cnt;

    logic          w_grant_a;
    logic          w_grant_b;
    logic          w_xfer_a;
    logic          w_xfer_b;
    logic [3:0]    w_cnt_next;

    // Grant selection: the current state decides which requester wins a tie;
    // no grant is issued while reset is held.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (reset_n) begin
            if (r_state == PRIO_A) begin
                if (a_valid)      w_grant_a = 1'b1;
                else if (b_valid) w_grant_b = 1'b1;
            end else begin
                if (b_valid)      w_grant_b = 1'b1;
                else if (a_valid) w_grant_a = 1'b1;
            end
        end
    end

    assign w_xfer_a = a_valid & w_grant_a;
    assign w_xfer_b = b_valid & w_grant_b;

    // Next starvation count: cleared when B is idle or served, otherwise
    // counts stalled cycles up to the limit.
    always_comb begin
        w_cnt_next = r_starve_cnt;
        if (!b_valid || w_xfer_b) begin
            w_cnt_next = 4'd0;
        end else if (r_starve_cnt < c_starve_limit) begin
            w_cnt_next = r_starve_cnt + 4'd1;
        end
    end

    // Arbitration state and starvation counter. The force decision looks at
    // the updated count so B wins on the cycle right after its last stall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= PRIO_A;
            r_starve_cnt <= 4'd0;
        end else begin
            r_starve_cnt <= w_cnt_next;
            case (r_state)
                PRIO_A: begin
                    if (w_cnt_next == c_starve_limit) r_state <= FORCE_B;
                end
                FORCE_B: begin
                    if (w_xfer_b || !b_valid) r_state <= PRIO_A;
                end
                default: r_state <= PRIO_A;
            endcase
        end
    end

    // Registered write port: every transfer loads address/data/source, but
    // only a non-zero destination raises the write enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_src   <= 1'b0;
        end else if (w_xfer_a) begin
            rf_we    <= (a_addr != '0);
            rf_waddr <= a_addr;
            rf_wdata <= a_data;
            rf_src   <= 1'b0;
        end else if (w_xfer_b) begin
            rf_we    <= (b_addr != '0);
            rf_waddr <= b_addr;
            rf_wdata <= b_data;
            rf_src   <= 1'b1;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;
    assign forced  = (r_state == FORCE_B);

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Directed self-checking bench for wb_port_arbiter (reset, A-only
//            write, starvation forcing, $0 write, same-address ordering and
//            B flush while forced).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset_n;
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_src;
    logic          forced;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.DW(DW), .AW(AW), .STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .a_valid  (a_valid),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_src   (rf_src),
        .forced   (forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s mismatch", tag);
        end
    endtask

    initial begin
        // 1. Reset held two cycles with both requesters active
        reset_n = 1'b0;
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h7777_0000;
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h6666_0000;
        tick();
        tick();
        #2;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_rf_src", rf_src, 0);
        chk("rst_forced", forced, 0);

        // 2. A only
        tick();
        reset_n = 1'b1;
        a_valid = 1'b1; a_addr = 5'd8; a_data = 32'hDEAD_BEEF;
        b_valid = 1'b0;
        #2;
        chk("a_only_a_ready", a_ready, 1);
        chk("a_only_b_ready", b_ready, 0);
        tick();
        a_valid = 1'b0;
        #2;
        chk("a_only_rf_we", rf_we, 1);
        chk("a_only_rf_waddr", rf_waddr, 8);
        chk("a_only_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("a_only_rf_src", rf_src, 0);

        // 3. Starvation: B stalls four cycles, then is forced
        tick();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h33;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("starve_b_ready", b_ready, 0);
            chk("starve_a_ready", a_ready, 1);
            chk("starve_forced", forced, 0);
            tick();
        end
        #2;
        chk("force_forced", forced, 1);
        chk("force_b_ready", b_ready, 1);
        chk("force_a_ready", a_ready, 0);
        tick();
        b_valid = 1'b0;
        #2;
        chk("force_rf_src", rf_src, 1);
        chk("force_rf_waddr", rf_waddr, 3);
        chk("force_rf_wdata", rf_wdata, 32'h33);
        chk("force_rf_we", rf_we, 1);
        chk("force_back_prio", forced, 0);
        chk("force_after_a_ready", a_ready, 1);

        // 4. Write to $0 is consumed but not enabled
        tick();
        a_addr = 5'd0; a_data = 32'h1;
        #2;
        chk("r0_a_ready", a_ready, 1);
        chk("r0_prev_waddr", rf_waddr, 1);
        chk("r0_prev_wdata", rf_wdata, 32'h11);
        tick();
        a_valid = 1'b0;
        #2;
        chk("r0_rf_we", rf_we, 0);
        chk("r0_rf_waddr", rf_waddr, 0);
        chk("r0_rf_wdata", rf_wdata, 32'h1);
        chk("r0_rf_src", rf_src, 0);

        // 5. Same address: forced B lands first, then A
        tick();
        a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h22;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hB;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("same_stall_b_ready", b_ready, 0);
            tick();
        end
        a_addr = 5'd9; a_data = 32'hA;
        #2;
        chk("same_b_ready", b_ready, 1);
        chk("same_a_ready", a_ready, 0);
        tick();
        b_valid = 1'b0;
        #2;
        chk("same_first_waddr", rf_waddr, 9);
        chk("same_first_wdata", rf_wdata, 32'hB);
        chk("same_first_src", rf_src, 1);
        chk("same_second_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        #2;
        chk("same_final_we", rf_we, 1);
        chk("same_final_waddr", rf_waddr, 9);
        chk("same_final_wdata", rf_wdata, 32'hA);
        chk("same_final_src", rf_src, 0);

        // 6. B flush while forced
        tick();
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h44;
        b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h55;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        b_valid = 1'b0;
        #2;
        chk("flush_forced", forced, 1);
        chk("flush_a_ready", a_ready, 1);
        chk("flush_b_ready", b_ready, 0);
        tick();
        #2;
        chk("flush_forced_clear", forced, 0);
        chk("flush_starve_cnt", dut.r_starve_cnt, 0);
        chk("flush_a_granted", a_ready, 1);
        chk("flush_rf_waddr", rf_waddr, 4);
        chk("flush_rf_src", rf_src, 0);
        tick();
        a_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
